// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer for the single-issue RV32I core: steps each instruction
// through FETCH/EXEC/MEM/WB, arbitrates the shared memory port and counts retirements.
module core_sequencer #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNTW    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [6:0]      opcode,
    input  logic            dec_regwr,
    input  logic            dec_memwr,
    input  logic            mem_ack,
    output logic            mem_req,
    output logic            mem_we,
    output logic            addr_sel,
    output logic            ir_we,
    output logic            pc_we,
    output logic            rf_we,
    output logic            fault,
    output logic [CNTW-1:0] retired,
    output logic [2:0]      state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        WB    = 3'd4,
        HALT  = 3'd5
    } state_t;

    // Wait counter only needs to reach TIMEOUT-1; it saturates beyond that.
    localparam int unsigned WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int unsigned TLIM_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [WW-1:0] TLIM = WW'(TLIM_I);
    localparam logic [WW-1:0] WMAX = '1;

    state_t            state_q;
    state_t            state_d;
    logic [WW-1:0]     wcnt_q;
    logic              fault_q;
    logic [CNTW-1:0]   retired_q;
    logic              timeout_c;

    assign timeout_c = (TIMEOUT != 0) && (wcnt_q == TLIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            fault_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == HALT) begin
                fault_q <= 1'b1;
            end
            if (state_q == WB) begin
                retired_q <= retired_q + CNTW'(1);
            end
            // Clear on entry to a request state, otherwise count un-acked request cycles.
            if ((state_d != state_q) && ((state_d == FETCH) || (state_d == MEM))) begin
                wcnt_q <= '0;
            end else if (((state_q == FETCH) || (state_q == MEM)) && !mem_ack
                         && (wcnt_q != WMAX)) begin
                wcnt_q <= wcnt_q + WW'(1);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        rf_we    = 1'b0;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we   = 1'b1;
                    state_d = EXEC;
                end else if (timeout_c) begin
                    state_d = HALT;
                end
            end
            EXEC: begin
                case (opcode)
                    7'b0000011, 7'b0100011: state_d = MEM;
                    7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111,
                    7'b1100111, 7'b0110111, 7'b0010111: state_d = WB;
                    default: state_d = HALT;
                endcase
            end
            MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = dec_memwr;
                if (mem_ack) begin
                    state_d = WB;
                end else if (timeout_c) begin
                    state_d = HALT;
                end
            end
            WB: begin
                rf_we   = dec_regwr;
                pc_we   = 1'b1;
                state_d = FETCH;
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    assign fault   = fault_q;
    assign retired = retired_q;
    assign state   = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Randomised bench for core_sequencer: an instruction-level plan is expanded into the
// per-cycle outputs the sequencer must show, and every cycle is compared against it.
module tb_core_sequencer;

    localparam int unsigned TO = 4;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst_n;
    logic [6:0]    opcode;
    logic          dec_regwr;
    logic          dec_memwr;
    logic          mem_ack;
    logic          mem_req;
    logic          mem_we;
    logic          addr_sel;
    logic          ir_we;
    logic          pc_we;
    logic          rf_we;
    logic          fault;
    logic [CW-1:0] retired;
    logic [2:0]    state;

    core_sequencer #(.TIMEOUT(TO), .CNTW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .dec_regwr(dec_regwr),
        .dec_memwr(dec_memwr), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we),
        .fault(fault), .retired(retired), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    st;
        logic          req;
        logic          we;
        logic          asel;
        logic          irwe;
        logic          pcwe;
        logic          rfwe;
        logic          flt;
        logic [CW-1:0] ret;
    } obs_t;

    int checks = 0;
    int fails  = 0;
    int cycno  = 0;
    int mr     = 0;

    logic [6:0] alu_ops [7] = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111,
                                7'b1100111, 7'b0110111, 7'b0010111};

    function automatic obs_t mk(int st, bit req, bit we, bit asel, bit irwe, bit pcwe,
                                bit rfwe, bit flt, int ret);
        obs_t o;
        o.st = 3'(st); o.req = req; o.we = we; o.asel = asel; o.irwe = irwe;
        o.pcwe = pcwe; o.rfwe = rfwe; o.flt = flt; o.ret = CW'(ret);
        return o;
    endfunction

    function automatic bit is_alu(logic [6:0] op);
        foreach (alu_ops[i]) if (alu_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit is_mem(logic [6:0] op);
        return (op == 7'b0000011) || (op == 7'b0100011);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive ack, compare outputs mid-cycle, advance to just after next edge.
    task automatic cyc(input bit ack, input obs_t e);
        obs_t g;
        mem_ack = ack;
        #3;
        g = {state, mem_req, mem_we, addr_sel, ir_we, pc_we, rf_we, fault, retired};
        checks++;
        if (g !== e) begin
            fails++;
            $display("FAIL cycle %0d: got %b expected %b (st,req,we,asel,ir_we,pc_we,rf_we,fault,retired)",
                     cycno, g, e);
        end
        cycno++;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n   = 1'b0;
        mem_ack = 1'b0;
        #1;
        check("reset_state", {29'd0, state}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mr    = 0;
        cyc(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic run_halt(input int n);
        for (int i = 0; i < n; i++) cyc(1'($urandom_range(0, 1)), mk(5, 0, 0, 0, 0, 0, 0, 1, mr));
    endtask

    // fd/md: un-acked cycles before the ack in FETCH/MEM. abort: MEM cycle to reset in (-1 none).
    task automatic run_instr(input logic [6:0] op, input int fd, input int md, input bit rw,
                             input bit mw, input int abort, output int ncyc, output bit halted);
        bit ack;
        ncyc = 0; halted = 1'b0;
        opcode = op; dec_regwr = rw; dec_memwr = mw;
        for (int c = 0; ; c++) begin
            ack = (c == fd);
            cyc(ack, mk(1, 1, 0, 0, ack, 0, 0, 0, mr));
            ncyc++;
            if (ack) break;
            if (c + 1 >= int'(TO)) begin halted = 1'b1; return; end
        end
        cyc(1'($urandom_range(0, 1)), mk(2, 0, 0, 0, 0, 0, 0, 0, mr));
        ncyc++;
        if (!is_alu(op) && !is_mem(op)) begin halted = 1'b1; return; end
        if (is_mem(op)) begin
            for (int c = 0; ; c++) begin
                ack = (c == md);
                if (c == abort) begin
                    mem_ack = 1'b0;
                    #2;
                    check("req_before_reset", {31'd0, mem_req}, 32'd1);
                    rst_n = 1'b0;
                    #1;
                    check("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
                    check("async_rst_state", {29'd0, state}, 32'd0);
                    check("async_rst_retired", {28'd0, retired}, 32'd0);
                    check("async_rst_fault", {31'd0, fault}, 32'd0);
                    @(posedge clk); #1;
                    @(posedge clk); #1;
                    rst_n = 1'b1;
                    mr    = 0;
                    cyc(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
                    return;
                end
                cyc(ack, mk(3, 1, mw, 1, 0, 0, 0, 0, mr));
                ncyc++;
                if (ack) break;
                if (c + 1 >= int'(TO)) begin halted = 1'b1; return; end
            end
        end
        cyc(1'($urandom_range(0, 1)), mk(4, 0, 0, 0, 0, 1, rw, 0, mr));
        ncyc++;
        mr = (mr + 1) % (1 << CW);
    endtask

    function automatic int rnd_delay();
        return ($urandom_range(0, 7) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
    endfunction

    initial begin
        int  n;
        bit  h;
        logic [6:0] op;
        rst_n = 1'b0; opcode = 7'd0; dec_regwr = 1'b0; dec_memwr = 1'b0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        reset_dut();
        run_instr(7'b0110011, 0, 0, 1'b1, 1'b0, -1, n, h);
        check("alu_cycles", 32'(n), 32'd3);
        check("alu_retired", {28'd0, retired}, 32'd1);
        run_instr(7'b0100011, 0, 2, 1'b0, 1'b1, -1, n, h);
        check("store_cycles", 32'(n), 32'd6);
        run_instr(7'b0000011, 1, 0, 1'b1, 1'b0, -1, n, h);
        run_instr(7'b0010011, 10, 0, 1'b1, 1'b0, -1, n, h);
        check("timeout_cycles", 32'(n), 32'd4);
        check("timeout_halted", {31'd0, h}, 32'd1);
        run_halt(3);
        check("timeout_fault", {31'd0, fault}, 32'd1);

        reset_dut();
        run_instr(7'b0110111, 3, 0, 1'b1, 1'b1, -1, n, h);
        check("late_ack_cycles", 32'(n), 32'd6);
        run_instr(7'b1111111, 0, 0, 1'b1, 1'b1, -1, n, h);
        check("illegal_halted", {31'd0, h}, 32'd1);
        run_halt(4);

        reset_dut();
        for (int i = 1; i <= 16; i++) begin
            run_instr(7'b0110011, 0, 0, 1'b1, 1'b0, -1, n, h);
            if (i == 15) check("retired_15", {28'd0, retired}, 32'd15);
        end
        check("retired_wrap", {28'd0, retired}, 32'd0);
        check("model_wrap", 32'(mr), 32'd0);
        run_instr(7'b0100011, 0, 3, 1'b0, 1'b1, 1, n, h);
        run_instr(7'b0110011, 0, 0, 1'b1, 1'b0, -1, n, h);

        for (int e = 0; e < 25; e++) begin
            reset_dut();
            for (int k = 0; k < 20; k++) begin
                int r;
                r = int'($urandom_range(0, 9));
                if (r < 5) op = alu_ops[$urandom_range(0, 6)];
                else if (r < 9) op = ($urandom_range(0, 1) != 0) ? 7'b0000011 : 7'b0100011;
                else begin
                    op = 7'($urandom);
                    while (is_alu(op) || is_mem(op)) op = 7'($urandom);
                end
                run_instr(op, rnd_delay(), rnd_delay(), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), -1, n, h);
                if (h) begin
                    run_halt(2);
                    break;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
